writeback_stage: RTL and testbench

//  - Final pipeline stage; sole driver of the regfile write port (dest_en/dest_addr/dest_data).
//  - Merges two result sources:
//    - ALU results: single cycle, priority, no buffering.
//    - Load-unit responses: queued in an in-order FIFO; drained on cycles the ALU does not write.
//  - Exports pend_mask so the upstream hazard unit can stall readers of pending load targets.

---
 rtl/writeback_stage.sv | 138 +++++++++++++
 tb/tb_writeback_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: ALU results win the regfile port, loads queue in an in-order FIFO.
// Optional WB_BYPASS_EN adds combinational forwarding of the output register.
module writeback_stage #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LQ_DEPTH   = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   input  logic [ADDR_WIDTH-1:0]    alu_rd,
   input  logic [WIDTH-1:0]         alu_data,
   output logic                     alu_stall,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [ADDR_WIDTH-1:0]    lsu_rd,
   input  logic [WIDTH-1:0]         lsu_data,
   output logic                     dest_en,
   output logic [ADDR_WIDTH-1:0]    dest_addr,
   output logic [WIDTH-1:0]         dest_data,
   output logic [2**ADDR_WIDTH-1:0] pend_mask
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_WIDTH-1:0]    rs1_addr,
   input  logic [ADDR_WIDTH-1:0]    rs2_addr,
   output logic                     rs1_fwd_en,
   output logic                     rs2_fwd_en,
   output logic [WIDTH-1:0]         rs1_fwd_data,
   output logic [WIDTH-1:0]         rs2_fwd_data
`endif
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = $clog2(LQ_DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [ADDR_WIDTH-1:0] rd_q  [LQ_DEPTH];
   logic [WIDTH-1:0]      dat_q [LQ_DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic                  dest_en_q, dest_en_d;
   logic [ADDR_WIDTH-1:0] dest_addr_q, dest_addr_d;
   logic [WIDTH-1:0]      dest_data_q, dest_data_d;

   logic empty, full, force_drain, push, pop, sel;
   logic [PW-1:0] idx;

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == CW'(LQ_DEPTH));
   assign force_drain = !empty && (starve_q == SW'(STARVE_MAX));
   assign alu_stall   = force_drain;
   assign lsu_ready   = !full;
   assign push        = lsu_valid && lsu_ready;
   assign pop         = force_drain || (!alu_valid && !empty);

   assign dest_en   = dest_en_q;
   assign dest_addr = dest_addr_q;
   assign dest_data = dest_data_q;

   always_comb begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   // Counter only advances when the ALU held the slot over a waiting load.
   always_comb begin
      starve_d = starve_q;
      if (pop || empty)
         starve_d = '0;
      else if (alu_valid && starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
   end

   always_comb begin
      sel         = 1'b0;
      dest_addr_d = dest_addr_q;
      dest_data_d = dest_data_q;
      if (pop) begin
         sel         = 1'b1;
         dest_addr_d = rd_q[rptr_q];
         dest_data_d = dat_q[rptr_q];
      end else if (alu_valid) begin
         sel         = 1'b1;
         dest_addr_d = alu_rd;
         dest_data_d = alu_data;
      end
      dest_en_d = sel && (dest_addr_d != '0);
   end

   always_comb begin
      pend_mask = '0;
      idx       = '0;
      for (int k = 0; k < LQ_DEPTH; k++) begin
         idx = rptr_q + PW'(k);
         if (k < int'(cnt_q))
            pend_mask[rd_q[idx]] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wptr_q]  <= lsu_rd;
         dat_q[wptr_q] <= lsu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         starve_q    <= '0;
         dest_en_q   <= 1'b0;
         dest_addr_q <= '0;
         dest_data_q <= '0;
      end else begin
         if (push)
            wptr_q <= wptr_q + 1'b1;
         if (pop)
            rptr_q <= rptr_q + 1'b1;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         dest_en_q   <= dest_en_d;
         dest_addr_q <= dest_addr_d;
         dest_data_q <= dest_data_d;
      end
   end

`ifdef WB_BYPASS_EN
   assign rs1_fwd_en   = dest_en_q && (dest_addr_q == rs1_addr);
   assign rs2_fwd_en   = dest_en_q && (dest_addr_q == rs2_addr);
   assign rs1_fwd_data = dest_data_q;
   assign rs2_fwd_data = dest_data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: queue-based reference model,
// random ALU/load traffic, starvation, full FIFO and mid-stream reset.
module tb_writeback_stage;

   localparam int W  = 32;
   localparam int AW = 5;
   localparam int D  = 4;
   localparam int SM = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [W-1:0]  alu_data;
   logic          alu_stall;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd;
   logic [W-1:0]  lsu_data;
   logic          dest_en;
   logic [AW-1:0] dest_addr;
   logic [W-1:0]  dest_data;
   logic [31:0]   pend_mask;
`ifdef WB_BYPASS_EN
   logic [AW-1:0] rs1_addr, rs2_addr;
   logic          rs1_fwd_en, rs2_fwd_en;
   logic [W-1:0]  rs1_fwd_data, rs2_fwd_data;
`endif

   always #5 clk = ~clk;

   writeback_stage #(.WIDTH(W), .ADDR_WIDTH(AW), .LQ_DEPTH(D), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_stall(alu_stall),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .dest_en(dest_en), .dest_addr(dest_addr), .dest_data(dest_data),
      .pend_mask(pend_mask)
`ifdef WB_BYPASS_EN
      ,
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_fwd_en(rs1_fwd_en), .rs2_fwd_en(rs2_fwd_en),
      .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
   );

   typedef struct {
      logic [AW-1:0] rd;
      logic [W-1:0]  d;
   } ent_t;

   typedef struct {
      logic          stall;
      logic          ready;
      logic [31:0]   mask;
      logic          f1;
      logic          f2;
      logic [W-1:0]  fdata;
   } comb_t;

   ent_t  lq[$];
   ent_t  wq[$];
   comb_t cq[$];
   int    starve;
   int    total = 0;
   int    bad   = 0;
   bit    in_rst;
   bit    alu_hold, lsu_hold;
   logic          m_en;
   logic [AW-1:0] m_addr;
   logic [W-1:0]  m_data;
   logic          r_av, r_lv;
   logic [AW-1:0] r_ard, r_lrd;
   logic [W-1:0]  r_ad, r_ld;
   ent_t  mw;
   comb_t mc;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic model_clear();
      lq.delete();
      wq.delete();
      cq.delete();
      starve   = 0;
      m_en     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      alu_hold = 1'b0;
      lsu_hold = 1'b0;
   endtask

   task automatic zero_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
`ifdef WB_BYPASS_EN
      rs1_addr = '0; rs2_addr = '0;
`endif
   endtask

   // One clock of stimulus: drive inputs, then step the reference model.
   task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic [W-1:0] ad,
                      input logic lv, input logic [AW-1:0] lrd, input logic [W-1:0] ld);
      comb_t c;
      ent_t  w, e;
      bit    take, popd, empty;
      @(posedge clk); #2;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      empty   = (lq.size() == 0);
      c.ready = (lq.size() < D);
      c.stall = !empty && (starve == SM);
      c.mask  = '0;
      foreach (lq[i]) c.mask[lq[i].rd] = 1'b1;
      c.mask[0] = 1'b0;
      c.f1 = 1'b0; c.f2 = 1'b0; c.fdata = m_data;
`ifdef WB_BYPASS_EN
      rs1_addr = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, 31));
      rs2_addr = AW'($urandom_range(0, 31));
      c.f1 = m_en && (m_addr == rs1_addr);
      c.f2 = m_en && (m_addr == rs2_addr);
`endif
      cq.push_back(c);
      take = 0; popd = 0;
      w.rd = '0; w.d = '0;
      if (c.stall || (!av && !empty)) begin
         w = lq.pop_front(); take = 1; popd = 1;
      end else if (av) begin
         w.rd = ard; w.d = ad; take = 1;
      end
      if (popd || empty) starve = 0;
      else if (starve < SM) starve++;
      if (lv && c.ready) begin
         e.rd = lrd; e.d = ld;
         lq.push_back(e);
      end
      if (take) begin
         m_addr = w.rd; m_data = w.d;
      end
      m_en = take && (w.rd != '0);
      if (m_en) wq.push_back(w);
      alu_hold = av && c.stall;
      lsu_hold = lv && !c.ready;
   endtask

   task automatic rstep(input int pa, input int pl);
      if (!alu_hold) begin
         r_av  = ($urandom_range(0, 99) < pa);
         r_ard = AW'($urandom_range(0, 31));
         r_ad  = $urandom;
      end
      if (!lsu_hold) begin
         r_lv  = ($urandom_range(0, 99) < pl);
         r_lrd = AW'($urandom_range(0, 31));
         r_ld  = $urandom;
      end
      cyc(r_av, r_ard, r_ad, r_lv, r_lrd, r_ld);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dest_en"},   64'(dest_en),   64'(0));
      chk({tag, "_pend_mask"}, 64'(pend_mask), 64'(0));
      chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'(1));
      chk({tag, "_alu_stall"}, 64'(alu_stall), 64'(0));
   endtask

   task automatic mid_reset();
      @(posedge clk); #3;
      rst_n  = 1'b0;
      in_rst = 1'b1;
      zero_inputs();
      model_clear();
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      in_rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!in_rst && cq.size() > 0) begin
         mc = cq.pop_front();
         chk("alu_stall", 64'(alu_stall), 64'(mc.stall));
         chk("lsu_ready", 64'(lsu_ready), 64'(mc.ready));
         chk("pend_mask", 64'(pend_mask), 64'(mc.mask));
`ifdef WB_BYPASS_EN
         chk("rs1_fwd_en", 64'(rs1_fwd_en), 64'(mc.f1));
         chk("rs2_fwd_en", 64'(rs2_fwd_en), 64'(mc.f2));
         if (mc.f1) chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'(mc.fdata));
         if (mc.f2) chk("rs2_fwd_data", 64'(rs2_fwd_data), 64'(mc.fdata));
`endif
      end
   end

   always @(posedge clk) begin
      #1;
      if (!in_rst && dest_en === 1'b1) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write: got addr %0h data %0h expected no write",
                     dest_addr, dest_data);
         end else begin
            mw = wq.pop_front();
            chk("dest_addr", 64'(dest_addr), 64'(mw.rd));
            chk("dest_data", 64'(dest_data), 64'(mw.d));
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      in_rst = 1'b1;
      zero_inputs();
      model_clear();
      r_av = 0; r_lv = 0; r_ard = '0; r_lrd = '0; r_ad = '0; r_ld = '0;
      #1;
      check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      in_rst = 1'b0;

      // ALU only, including an x0 write
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      cyc(1'b1, 5'd0, 32'h00001234, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, 1'b0, '0, '0);

      // Load drain with idle ALU
      cyc(1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
      cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h22);
      repeat (3) cyc(1'b0, '0, '0, 1'b0, '0, '0);

      // Continuous ALU with continuous loads: fill, backpressure, forced drains
      repeat (20) rstep(100, 100);
      repeat (D + SM + 2) cyc(1'b0, '0, '0, 1'b0, '0, '0);

      // Reset with three loads queued
      cyc(1'b1, 5'd11, 32'hA, 1'b1, 5'd3, 32'h33);
      cyc(1'b1, 5'd12, 32'hB, 1'b1, 5'd4, 32'h44);
      cyc(1'b1, 5'd13, 32'hC, 1'b1, 5'd6, 32'h66);
      mid_reset();

      repeat (600) rstep(20, 50);
      repeat (600) rstep(60, 50);
      repeat (600) rstep(90, 60);
      mid_reset();
      repeat (400) rstep(70, 60);

      repeat (D + SM + 4) cyc(1'b0, '0, '0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #2;
      chk("writes_outstanding", 64'(wq.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
